// File: rtl/dss_mac_sequencer.sv
// rtl/dss_mac_sequencer.sv - time-multiplexed 4-state DSS loop filter; DSS_SAT_EN adds output clamping and a sat port
module dss_mac_sequencer #(
  parameter int DATA_W = 20,
  parameter int COEF_W = 25,
  parameter int FRAC   = 23,
  parameter int ACC_W  = 48
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] u,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              busy,
  output logic              overrun,
`ifdef DSS_SAT_EN
  output logic              sat,
`endif
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata
);
  localparam int PROD_W = COEF_W + DATA_W;

  localparam logic [COEF_W-1:0] A0_RST [4] = '{25'h1FFEB6B, 25'h10040AB, 25'h1FFEB6B, 25'h1800000};
  localparam logic [COEF_W-1:0] C_RST  [4] = '{25'h18F5D27, 25'h0088055, 25'h1B21A18, 25'h0032FC9};
  localparam logic [COEF_W-1:0] D_RST      = 25'h1FCD037;

  typedef enum logic [2:0] {IDLE, MAC_A, MAC_C, MAC_D, DONE} state_t;

  state_t r_state, w_next;
  logic [1:0] r_idx, w_idx_next;

  logic signed [COEF_W-1:0] r_a  [4];
  logic signed [COEF_W-1:0] r_c  [4];
  logic signed [COEF_W-1:0] r_d;
  logic signed [COEF_W-1:0] r_sa [4];
  logic signed [COEF_W-1:0] r_sc [4];
  logic signed [COEF_W-1:0] r_sd;
  logic                     r_pending;
  logic                     r_overrun;

  logic signed [DATA_W-1:0] r_x [4];
  logic signed [DATA_W-1:0] r_u;
  logic signed [ACC_W-1:0]  r_acc_a;
  logic signed [ACC_W-1:0]  r_acc_y;
  logic [DATA_W-1:0]        r_y;
  logic                     r_y_valid;

  logic                     w_accept;
  logic                     w_busy;
  logic                     w_commit_wr;
  logic                     w_clear_wr;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [DATA_W-1:0] w_data;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic [DATA_W-1:0]        w_x0_next;
  logic [DATA_W-1:0]        w_y_next;

  assign w_busy      = (r_state == MAC_A) || (r_state == MAC_C) || (r_state == MAC_D);
  assign w_accept    = tick && ((r_state == IDLE) || (r_state == DONE));
  assign w_commit_wr = cfg_we && (cfg_addr == 4'd15);
  assign w_clear_wr  = cfg_we && (cfg_addr == 4'd14);

  // Steer the single multiplier: A-row, C-row, then D against the latched input
  always_comb begin
    w_coef = '0;
    w_data = '0;
    case (r_state)
      MAC_A: begin
        w_coef = r_a[r_idx];
        w_data = r_x[r_idx];
      end
      MAC_C: begin
        w_coef = r_c[r_idx];
        w_data = r_x[r_idx];
      end
      MAC_D: begin
        w_coef = r_d;
        w_data = r_u;
      end
      default: ;
    endcase
  end

  assign w_prod     = w_coef * w_data;
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

`ifdef DSS_SAT_EN
  localparam int HI_W = ACC_W - FRAC;
  localparam logic signed [HI_W:0] SAT_MAX = (HI_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [HI_W:0] SAT_MIN = ~SAT_MAX;

  logic signed [HI_W:0] w_a_sum;
  logic signed [HI_W:0] w_y_wide;
  logic                 w_y_clamp;

  // Full-width rescaled sums, clamped to the DATA_W range instead of wrapping
  always_comb begin
    w_a_sum   = $signed(r_acc_a[ACC_W-1:FRAC]) + r_u;
    w_y_wide  = $signed(r_acc_y[ACC_W-1:FRAC]);
    w_y_clamp = (w_y_wide > SAT_MAX) || (w_y_wide < SAT_MIN);
    if (w_a_sum > SAT_MAX)      w_x0_next = SAT_MAX[DATA_W-1:0];
    else if (w_a_sum < SAT_MIN) w_x0_next = SAT_MIN[DATA_W-1:0];
    else                        w_x0_next = w_a_sum[DATA_W-1:0];
    if (w_y_wide > SAT_MAX)      w_y_next = SAT_MAX[DATA_W-1:0];
    else if (w_y_wide < SAT_MIN) w_y_next = SAT_MIN[DATA_W-1:0];
    else                         w_y_next = w_y_wide[DATA_W-1:0];
  end

  assign sat = (r_state == DONE) && w_y_clamp;
`else
  assign w_x0_next = r_acc_a[FRAC+DATA_W-1:FRAC] + r_u;
  assign w_y_next  = r_acc_y[FRAC+DATA_W-1:FRAC];
`endif

  // Sequencer state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
    end
  end

  // Next state: four A products, four C products, one D product, then the update cycle
  always_comb begin
    w_next     = r_state;
    w_idx_next = r_idx;
    case (r_state)
      IDLE: begin
        w_idx_next = 2'd0;
        if (tick) w_next = MAC_A;
      end
      MAC_A: begin
        w_idx_next = r_idx + 2'd1;
        if (r_idx == 2'd3) w_next = MAC_C;
      end
      MAC_C: begin
        w_idx_next = r_idx + 2'd1;
        if (r_idx == 2'd3) w_next = MAC_D;
      end
      MAC_D: w_next = DONE;
      DONE: begin
        w_idx_next = 2'd0;
        w_next     = tick ? MAC_A : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Accumulators, input latch and the end-of-sequence state/output update
  always_ff @(posedge clock) begin
    if (reset) begin
      r_u       <= '0;
      r_acc_a   <= '0;
      r_acc_y   <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
      for (int i = 0; i < 4; i++) r_x[i] <= '0;
    end else begin
      r_y_valid <= 1'b0;
      if (w_accept) begin
        r_u     <= u;
        r_acc_a <= '0;
        r_acc_y <= '0;
      end else if (r_state == MAC_A) begin
        r_acc_a <= r_acc_a + w_prod_ext;
      end else if ((r_state == MAC_C) || (r_state == MAC_D)) begin
        r_acc_y <= r_acc_y + w_prod_ext;
      end
      if (r_state == DONE) begin
        r_x[0]    <= w_x0_next;
        r_x[1]    <= r_x[0];
        r_x[2]    <= r_x[1];
        r_x[3]    <= r_x[2];
        r_y       <= w_y_next;
        r_y_valid <= 1'b1;
      end
    end
  end

  // Shadow writes, commit hand-off at tick acceptance, sticky overrun (set beats clear)
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_a[i]  <= A0_RST[i];
        r_sa[i] <= A0_RST[i];
        r_c[i]  <= C_RST[i];
        r_sc[i] <= C_RST[i];
      end
      r_d       <= D_RST;
      r_sd      <= D_RST;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          4'd0, 4'd1, 4'd2, 4'd3: r_sa[cfg_addr[1:0]] <= cfg_wdata;
          4'd4, 4'd5, 4'd6, 4'd7: r_sc[cfg_addr[1:0]] <= cfg_wdata;
          4'd8:                   r_sd <= cfg_wdata;
          default: ;
        endcase
      end
      if (w_accept && r_pending) begin
        for (int i = 0; i < 4; i++) begin
          r_a[i] <= r_sa[i];
          r_c[i] <= r_sc[i];
        end
        r_d <= r_sd;
      end
      if (w_commit_wr)   r_pending <= 1'b1;
      else if (w_accept) r_pending <= 1'b0;
      if (tick && w_busy)  r_overrun <= 1'b1;
      else if (w_clear_wr) r_overrun <= 1'b0;
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign busy    = w_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_dss_mac_sequencer.sv
// tb/tb_dss_mac_sequencer.sv - randomized scoreboard bench for dss_mac_sequencer
module tb_dss_mac_sequencer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic [19:0] u = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [24:0] cfg_wdata = '0;
  logic [19:0] y;
  logic        y_valid, busy, overrun;
`ifdef DSS_SAT_EN
  logic        sat;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  dss_mac_sequencer dut (
    .clock(clock), .reset(reset), .tick(tick), .u(u), .y(y), .y_valid(y_valid),
    .busy(busy), .overrun(overrun),
`ifdef DSS_SAT_EN
    .sat(sat),
`endif
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: filter coefficients and state as plain signed integers
  longint m_a[4], m_c[4], m_d, s_a[4], s_c[4], s_d, m_x[4];
  bit     m_pend, m_ovr, m_seq;
  int     m_last;

  typedef struct { longint y; int due; bit sat; } exp_t;
  exp_t q[$];

  function automatic longint sx(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  function automatic longint clamp20(input longint v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  task automatic model_init();
    longint ra[4], rc[4];
    ra = '{sx(64'h1FFEB6B, 25), sx(64'h10040AB, 25), sx(64'h1FFEB6B, 25), sx(64'h1800000, 25)};
    rc = '{sx(64'h18F5D27, 25), sx(64'h0088055, 25), sx(64'h1B21A18, 25), sx(64'h0032FC9, 25)};
    for (int i = 0; i < 4; i++) begin
      m_a[i] = ra[i]; s_a[i] = ra[i];
      m_c[i] = rc[i]; s_c[i] = rc[i];
      m_x[i] = 0;
    end
    m_d = sx(64'h1FCD037, 25);
    s_d = m_d;
    m_pend = 0; m_ovr = 0; m_seq = 0; m_last = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [24:0] d);
    longint v;
    v = sx(longint'(d), 25);
    if (a < 4) s_a[a] = v;
    else if (a < 8) s_c[a-4] = v;
    else if (a == 8) s_d = v;
    else if (a == 14) m_ovr = 0;
    else if (a == 15) m_pend = 1;
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  // A tick is taken only when no sequence started within the last 9 edges
  task automatic drive_tick(input logic [19:0] uv);
    int e;
    longint acc_a, acc_y, ua, nx0, ny;
    exp_t ent;
    e = cyc + 1;
    if (!m_seq || (e - m_last >= 10)) begin
      if (m_pend) begin
        for (int i = 0; i < 4; i++) begin m_a[i] = s_a[i]; m_c[i] = s_c[i]; end
        m_d = s_d;
        m_pend = 0;
      end
      ua = sx(longint'(uv), 20);
      acc_a = 0; acc_y = 0;
      for (int i = 0; i < 4; i++) begin
        acc_a += m_a[i] * m_x[i];
        acc_y += m_c[i] * m_x[i];
      end
      acc_y += m_d * ua;
`ifdef DSS_SAT_EN
      nx0 = clamp20((sx(acc_a, 48) >>> 23) + ua);
      ny  = clamp20(sx(acc_y, 48) >>> 23);
      ent.sat = (ny != (sx(acc_y, 48) >>> 23));
`else
      nx0 = sx((acc_a >>> 23) + ua, 20);
      ny  = sx(acc_y >>> 23, 20);
      ent.sat = 0;
`endif
      m_x[3] = m_x[2]; m_x[2] = m_x[1]; m_x[1] = m_x[0]; m_x[0] = nx0;
      ent.y = ny & 64'hFFFFF;
      ent.due = e + 10;
      q.push_back(ent);
      m_last = e;
      m_seq = 1;
    end else begin
      m_ovr = 1;
    end
    tick = 1'b1; u = uv;
    @(negedge clock);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    model_init();
    idle(2);
    reset = 1'b0;
  endtask

  // Output scoreboard: every y_valid must match the oldest expected result on its due cycle
  always @(negedge clock) begin
    if (!reset) begin
`ifdef DSS_SAT_EN
      if (q.size() > 0 && cyc == q[0].due - 1) check("sat_pulse", sat, q[0].sat);
`endif
      if (y_valid === 1'b1) begin
        if (q.size() == 0) check("yv_spurious", 1, 0);
        else begin
          check("yv_latency", cyc, q[0].due);
          check("y_value", y, q[0].y);
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc >= q[0].due) begin
        check("yv_missing", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    model_init();
    idle(3);
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    idle(2);

    // First evaluation from reset
    drive_tick(20'h00800);
    check("busy_in_seq", busy, 1);
    idle(14);
    check("idle_busy", busy, 0);

    // Back-to-back ticks at the minimum period
    for (int n = 0; n < 64; n++) begin
      drive_tick(20'h04000);
      idle(9);
    end
    idle(12);
    check("b2b_overrun", overrun, 0);

    // Tick at E5 is dropped and flagged; clear via address 14
    drive_tick(20'($urandom));
    idle(4);
    drive_tick(20'($urandom));
    check("ovr_set", overrun, 1);
    idle(10);
    check("ovr_sticky", overrun, 1);
    cfg_write(4'd14, 25'($urandom));
    check("ovr_clear", overrun, 0);

    // Shadow write without commit leaves the active D in place
    cfg_write(4'd8, 25'h0800000);
    drive_tick(20'h00100);
    idle(14);

    // Commit from a zeroed state: y = 1.0 * u
    do_reset();
    cfg_write(4'd8, 25'h0800000);
    cfg_write(4'd15, 25'($urandom));
    drive_tick(20'h00100);
    idle(14);
    check("commit_y", y, 20'h00100);

    // Reset in the middle of a sequence
    do_reset();
    drive_tick(20'h00800);
    idle(5);
    reset = 1'b1;
    q.delete();
    model_init();
    @(negedge clock);
    check("mid_rst_y", y, 0);
    check("mid_rst_y_valid", y_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_overrun", overrun, 0);
    reset = 1'b0;
    idle(15);
    drive_tick(20'h00800);
    idle(14);

    // Randomized ticks, gaps and configuration traffic
    for (int n = 0; n < 60; n++) begin
      int k, gap;
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        logic [3:0] a;
        logic [24:0] d;
        a = 4'($urandom_range(0, 15));
        d = ($urandom_range(0, 3) == 0) ? 25'($urandom) : 25'(sx(longint'($urandom_range(0, 16'hFFFF)), 16) <<< 7);
        cfg_write(a, d);
      end
      drive_tick(20'($urandom));
      check("rnd_overrun", overrun, m_ovr);
      gap = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 8) : $urandom_range(9, 12);
      idle(gap);
    end
    idle(14);

    // Large input with unity C and an integrating x0: wraps, or clamps with DSS_SAT_EN
    do_reset();
    for (int i = 0; i < 4; i++) cfg_write(4'(4 + i), 25'h0800000);
    cfg_write(4'd0, 25'h0800000);
    cfg_write(4'd15, 25'd0);
    for (int n = 0; n < 8; n++) begin
      drive_tick(20'h7FFFF);
      idle(9);
    end
    idle(14);

    check("queue_drained", q.size(), 0);
    check("final_overrun", overrun, m_ovr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
